// File: rtl/uart_rx_queue.sv
// UART receive path: 8N1 deserialiser timed by the shared baud divisor,
// feeding an 8-entry circular byte queue drained through the processor port.
module uart_rx_queue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       iorw_n,
    input  logic       iocs_n,
    input  logic [1:0] ioaddr,
    input  logic [7:0] DBL,
    input  logic [4:0] DBH,
    output logic [7:0] rx_rdata,
    output logic       rx_queue_empty,
    output logic [3:0] rx_num_filled,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [12:0] divisor;
    logic [12:0] baud_cnt, baud_next;
    logic [3:0]  bit_cnt, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        sample, push, frame_err_set;

    logic [7:0]  queue_mem [8];
    logic [3:0]  wr_ptr, rd_ptr, count;
    logic        full, pop, flag_clear;

    assign divisor = {DBH, DBL};
    assign sample  = (state != IDLE) && (baud_cnt == 13'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 13'h01b2;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'd0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    // Half-period load on start detect puts every later sample at mid-bit.
    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_cnt;
        shift_next    = shift_reg;
        push          = 1'b0;
        frame_err_set = 1'b0;
        if (state != IDLE) begin
            baud_next = sample ? divisor : baud_cnt - 13'd1;
        end
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    baud_next  = divisor >> 1;
                    bit_next   = 4'd0;
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    push          = rx_s;
                    frame_err_set = !rx_s;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count          = wr_ptr - rd_ptr;
    assign full           = (count == 4'd8);
    assign rx_queue_empty = (count == 4'd0);
    assign rx_num_filled  = count;
    assign rx_rdata       = queue_mem[rd_ptr[2:0]];
    assign pop            = !iocs_n && iorw_n && (ioaddr == 2'b00) && !rx_queue_empty;
    assign flag_clear     = !iocs_n && !iorw_n && (ioaddr == 2'b01);

    always_ff @(posedge clk) begin
        if (push && !full) begin
            queue_mem[wr_ptr[2:0]] <= shift_reg;
        end
    end

    // Full is judged before any same-cycle pop, so a push into a full queue drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= 4'd0;
            rd_ptr       <= 4'd0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            if (push && full) begin
                rx_overrun <= 1'b1;
            end else if (flag_clear) begin
                rx_overrun <= 1'b0;
            end
            if (frame_err_set) begin
                rx_frame_err <= 1'b1;
            end else if (flag_clear) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_queue.sv
// Self-checking bench for uart_rx_queue: drives serial frames and processor
// reads, comparing against a byte-queue reference model.
module tb_uart_rx_queue;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       iorw_n;
    logic       iocs_n;
    logic [1:0] ioaddr;
    logic [7:0] dbl;
    logic [4:0] dbh;
    logic [7:0] rx_rdata;
    logic       rx_queue_empty;
    logic [3:0] rx_num_filled;
    logic       rx_overrun;
    logic       rx_frame_err;

    int compared;
    int mismatched;

    logic [7:0] model_q [$];
    logic       model_overrun;
    logic       model_frame_err;

    uart_rx_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RX            (rx),
        .iorw_n        (iorw_n),
        .iocs_n        (iocs_n),
        .ioaddr        (ioaddr),
        .DBL           (dbl),
        .DBH           (dbh),
        .rx_rdata      (rx_rdata),
        .rx_queue_empty(rx_queue_empty),
        .rx_num_filled (rx_num_filled),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() == 8) model_overrun = 1'b1;
        else model_q.push_back(b);
    endfunction

    function automatic logic [3:0] model_count();
        return 4'(model_q.size());
    endfunction

    task automatic set_divisor(input int d);
        logic [12:0] dv;
        dv  = 13'(d);
        dbh = dv[12:8];
        dbl = dv[7:0];
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; each bit lasts d+1 cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (d + 1) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic read_strobe(output logic [7:0] data);
        iocs_n = 1'b0;
        iorw_n = 1'b1;
        ioaddr = 2'b00;
        #1 data = rx_rdata;
        @(posedge clk);
        #1;
        iocs_n = 1'b1;
    endtask

    task automatic clear_flags();
        iocs_n = 1'b0;
        iorw_n = 1'b0;
        ioaddr = 2'b01;
        @(posedge clk);
        #1;
        iocs_n = 1'b1;
        iorw_n = 1'b1;
        ioaddr = 2'b00;
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        idle_cycles(3);
        model_q.delete();
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
        compared++;
        if (rx_queue_empty !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_empty: got %b expected 1", rx_queue_empty);
        end
        compared++;
        if (rx_num_filled !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %0d expected 0", rx_num_filled);
        end
        compared++;
        if ({rx_overrun, rx_frame_err} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b%b expected 00", rx_overrun, rx_frame_err);
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        set_divisor(15);
        fork
            send_frame(8'hA5, 1'b1, 15);
            begin
                repeat (154) @(posedge clk);
                #1;
                compared++;
                if (rx_num_filled !== 4'd0) begin
                    mismatched++;
                    $display("[TB] FAIL single_pre_push_count: got %0d expected 0", rx_num_filled);
                end
                @(posedge clk);
                #1;
                compared++;
                if (rx_num_filled !== 4'd1) begin
                    mismatched++;
                    $display("[TB] FAIL single_post_push_count: got %0d expected 1", rx_num_filled);
                end
            end
        join
        model_push(8'hA5);
        compared++;
        if (rx_rdata !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL single_rdata: got %h expected a5", rx_rdata);
        end
        read_strobe(got);
        void'(model_q.pop_front());
        compared++;
        if (rx_queue_empty !== 1'b1 || rx_num_filled !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL single_drain: got empty=%b count=%0d expected empty=1 count=0",
                     rx_queue_empty, rx_num_filled);
        end
    endtask

    task automatic test_glitch();
        set_divisor(15);
        rx = 1'b0;
        idle_cycles(4);
        rx = 1'b1;
        idle_cycles(40);
        compared++;
        if (rx_num_filled !== model_count() || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch: got count=%0d ovr=%b ferr=%b expected count=%0d ovr=0 ferr=0",
                     rx_num_filled, rx_overrun, rx_frame_err, model_count());
        end
        send_frame(8'h81, 1'b1, 15);
        model_push(8'h81);
        compared++;
        if (rx_num_filled !== model_count() || rx_rdata !== 8'h81) begin
            mismatched++;
            $display("[TB] FAIL glitch_recover: got count=%0d data=%h expected count=%0d data=81",
                     rx_num_filled, rx_rdata, model_count());
        end
    endtask

    task automatic test_frame_error();
        set_divisor(15);
        send_frame(8'h3C, 1'b0, 15);
        idle_cycles(32);
        model_frame_err = 1'b1;
        compared++;
        if (rx_frame_err !== 1'b1 || rx_num_filled !== model_count()) begin
            mismatched++;
            $display("[TB] FAIL frame_err_set: got ferr=%b count=%0d expected ferr=1 count=%0d",
                     rx_frame_err, rx_num_filled, model_count());
        end
        clear_flags();
        compared++;
        if (rx_frame_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL frame_err_clear: got %b expected 0", rx_frame_err);
        end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] got;
        logic [7:0] exp;
        set_divisor(15);
        while (model_q.size() > 0) begin
            read_strobe(got);
            void'(model_q.pop_front());
        end
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(i), 1'b1, 15);
            model_push(8'(i));
        end
        compared++;
        if (rx_num_filled !== 4'd8 || rx_overrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fill_full: got count=%0d ovr=%b expected count=8 ovr=0",
                     rx_num_filled, rx_overrun);
        end
        send_frame(8'h08, 1'b1, 15);
        model_push(8'h08);
        compared++;
        if (rx_num_filled !== model_count() || rx_overrun !== model_overrun) begin
            mismatched++;
            $display("[TB] FAIL fill_overrun: got count=%0d ovr=%b expected count=%0d ovr=%b",
                     rx_num_filled, rx_overrun, model_count(), model_overrun);
        end
        for (int i = 0; i < 8; i++) begin
            exp = model_q.pop_front();
            read_strobe(got);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL fill_read_%0d: got %h expected %h", i, got, exp);
            end
        end
        compared++;
        if (rx_queue_empty !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fill_empty: got %b expected 1", rx_queue_empty);
        end
        clear_flags();
        compared++;
        if (rx_overrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", rx_overrun);
        end
    endtask

    // Read strobes land on the stop-sample edge (155 edges after frame start at D=15).
    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] b;
        logic [7:0] exp;
        logic [3:0] steady;
        set_divisor(15);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 15);
            model_push(b);
        end
        steady = model_count();
        for (int i = 0; i < 20; i++) begin
            b   = 8'($urandom);
            exp = model_q[0];
            fork
                send_frame(b, 1'b1, 15);
                begin
                    repeat (154) @(posedge clk);
                    #1;
                    iocs_n = 1'b0;
                    iorw_n = 1'b1;
                    ioaddr = 2'b00;
                    #1;
                    compared++;
                    if (rx_rdata !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL wrap_data_%0d: got %h expected %h", i, rx_rdata, exp);
                    end
                    @(posedge clk);
                    #1;
                    iocs_n = 1'b1;
                end
            join
            void'(model_q.pop_front());
            model_push(b);
            compared++;
            if (rx_num_filled !== steady || rx_overrun !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL wrap_count_%0d: got count=%0d ovr=%b expected count=%0d ovr=0",
                         i, rx_num_filled, rx_overrun, steady);
            end
        end
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            read_strobe(got);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL wrap_drain: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] b;
        logic       stop_bit;
        int         d;
        for (int i = 0; i < 14; i++) begin
            d        = int'($urandom_range(40, 8));
            b        = 8'($urandom);
            stop_bit = ($urandom_range(5, 0) != 0);
            set_divisor(d);
            send_frame(b, stop_bit, d);
            if (stop_bit) begin
                model_push(b);
                idle_cycles(int'($urandom_range(3, 0)));
            end else begin
                model_frame_err = 1'b1;
                idle_cycles(2 * (d + 1));
            end
            compared++;
            if (rx_num_filled !== model_count() || rx_frame_err !== model_frame_err ||
                rx_overrun !== model_overrun) begin
                mismatched++;
                $display("[TB] FAIL random_state_%0d: got count=%0d ferr=%b ovr=%b expected count=%0d ferr=%b ovr=%b",
                         i, rx_num_filled, rx_frame_err, rx_overrun, model_count(),
                         model_frame_err, model_overrun);
            end
            if (model_q.size() > 0 && $urandom_range(1, 0) == 1) begin
                exp = model_q.pop_front();
                read_strobe(got);
                compared++;
                if (got !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL random_read_%0d: got %h expected %h", i, got, exp);
                end
            end
        end
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            read_strobe(got);
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("[TB] FAIL random_drain: got %h expected %h", got, exp);
            end
        end
        clear_flags();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bits;
        logic [7:0] got;
        set_divisor(15);
        send_frame(8'h11, 1'b1, 15);
        model_push(8'h11);
        send_frame(8'h22, 1'b0, 15);
        idle_cycles(32);
        bits = 8'hC3;
        rx = 1'b0;
        idle_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx = bits[i];
            idle_cycles(16);
        end
        rx = bits[4];
        idle_cycles(8);
        rst_n = 1'b0;
        rx    = 1'b1;
        #2;
        model_q.delete();
        model_overrun   = 1'b0;
        model_frame_err = 1'b0;
        compared++;
        if (rx_queue_empty !== 1'b1 || rx_num_filled !== 4'd0 ||
            rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midframe_reset: got empty=%b count=%0d ovr=%b ferr=%b expected 1/0/0/0",
                     rx_queue_empty, rx_num_filled, rx_overrun, rx_frame_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(5);
        send_frame(8'h5A, 1'b1, 15);
        model_push(8'h5A);
        compared++;
        if (rx_num_filled !== model_count() || rx_frame_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_count: got count=%0d ferr=%b expected count=%0d ferr=0",
                     rx_num_filled, rx_frame_err, model_count());
        end
        read_strobe(got);
        void'(model_q.pop_front());
        compared++;
        if (got !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL post_reset_data: got %h expected 5a", got);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        rx         = 1'b1;
        iorw_n     = 1'b1;
        iocs_n     = 1'b1;
        ioaddr     = 2'b00;
        dbl        = 8'd15;
        dbh        = 5'd0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_fill_overrun();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
